wb_arbiter: RTL and testbench
=============================

# wb_arbiter

Writeback arbiter that drives the two register-file write ports of the dual-issue core. It merges the two in-order pipe results with results from the long-latency unit (mul/div, uncached load) through a small in-order queue. Queued long-latency results fill whichever write ports the pipes leave idle. A queued result is cancelled when a younger pipe write targets the same register. All port outputs are registered, so the register file sees one writeback stage.

## Interface
Parameters:
- DEPTH, 4, long-latency queue entries; power of two, ≥2

Ports:
- clk  in  1  clock
- resetn  in  1  reset, synchronous, active-low
- p1_valid  in  1  pipe-1 (older slot) result valid
- p1_rd  in  5  pipe-1 destination (regid_t)
- p1_data  in  32  pipe-1 result (word_t)
- p2_valid / p2_rd / p2_data  in  1/5/32  pipe-2 (younger slot) result
- ll_valid  in  1  long-latency result offered
- ll_ready  out  1  queue can accept
- ll_rd / ll_data  in  5/32  long-latency destination / result
- we1 / wa1 / wd1  out  1/5/32  to regfile write_en1 / wa5 / wd5
- we2 / wa2 / wd2  out  1/5/32  to regfile write_en2 / wa6 / wd6 (port 2 wins on equal address)
- pending_mask  out  32  bit r set while a live queued result targets r; bit 0 always 0

## Operation
- A pipe input with rd==0 is treated as invalid. An accepted ll with rd==0 is dropped, not enqueued.
- Kill:
  - Each cycle, every queued entry whose rd equals a valid nonzero p1_rd or p2_rd is marked dead.
  - Kill is evaluated combinationally, before the drain decision of the same cycle.
  - An ll accepted in that same cycle is enqueued live.
- Port assignment per cycle:
  - p1 takes port 1 and p2 takes port 2.
  - Ports left free receive live queue entries in order. The oldest live entry goes to the lower-numbered free port.
  - If both ports are free, up to two live entries drain, older on port 1.
- Dead entries at the head pop without using a port. At most 2 pops per cycle total (live + dead). A dead entry is never written.
- Enqueue: an ll handshake (ll_valid & ll_ready) appends at the tail. There is no bypass to the ports.
- ll_ready = (count < DEPTH) & resetn. It is computed from registered count only, independent of ll_valid and of same-cycle pops.
- Queue pointers wrap modulo DEPTH. count ranges 0..DEPTH and is stored in $clog2(DEPTH)+1 bits.
- pending_mask = OR of one-hot(rd) over live entries. It is combinational from queue state.

## Timing
- Pipe result: it appears on weN/waN/wdN the cycle after valid (latency 1).
- Long-latency result: accepted in cycle t, it is written no earlier than t+2 (enqueue, then drain, then output register).
- Reset:
  - Queue empties and all live bits clear.
  - we1 = we2 = 0; wa1/wa2/wd1/wd2 = 0; pending_mask = 0; ll_ready = 0 while resetn is low.
  - Reset mid-operation discards all queued results.
- When weN = 0, waN/wdN hold 0.
- Full queue with a simultaneous pop: ll_ready is still 0 that cycle. The slot becomes acceptable next cycle.
- p1 and p2 writing the same rd: both are issued. Port 2 priority in the regfile gives the younger (p2) value.

## Structure
- Shared package: word_t, regid_t (already common); wb_req_t {valid, rd, data}; WB_DEPTH default.
- Sub-module wb_queue:
  - Circular buffer with per-entry live bit.
  - Kill compare against two addresses.
  - Exposes head/head+1 entries and a 0–2 pop count.
  - Produces count and pending_mask.
- wb_arbiter holds the port-select logic and the output registers.

## Test plan
- Reset: hold resetn=0 with p1_valid=1 → we1=we2=0, ll_ready=0; after release, ll_ready=1, pending_mask=0.
- Pipe pass-through: p1 (r3, 0x11) and p2 (r3, 0x22) in one cycle → next cycle we1=we2=1, wa1=wa2=3, wd2=0x22.
- Drain into idle ports:
  - Enqueue ll r5=0xA, then r6=0xB, with pipes idle.
  - r5 appears on port 1 two cycles after acceptance, with pending_mask bit5 set in between.
  - With only p1 busy, the queued entry uses port 2.
- Kill: queue ll r7=0x5, then p2 writes r7=0x9 the next cycle → only 0x9 is written to r7; pending_mask[7] clears; the dead entry pops without using a port.
- Full/wrap:
  - Fill DEPTH entries while both pipes are busy → ll_ready=0 and extra ll_valid is held off.
  - Free the ports → entries drain two per cycle in order.
  - Continue 3×DEPTH transfers to exercise pointer wrap with no loss or reordering.
- rd==0: ll r0 is accepted and dropped, and p1 r0 gives we1=0.

Source files
------------

// File: rtl/wb_pkg.sv
// wb_pkg: types and defaults shared by the writeback arbiter and its queue.
//   word_t   - 32-bit register-file data word
//   regid_t  - 5-bit architectural register index (r0 is the zero register)
//   wb_req_t - one writeback request {valid, rd, data}
//   WB_DEPTH - default long-latency queue depth
package wb_pkg;

    typedef logic [31:0] word_t;
    typedef logic [4:0]  regid_t;

    typedef struct packed {
        logic   valid;
        regid_t rd;
        word_t  data;
    } wb_req_t;

    localparam int WB_DEPTH = 4;

endpackage

// File: rtl/wb_queue.sv
// wb_queue: in-order circular buffer of long-latency results, with a live bit
// per entry. Any entry whose rd matches one of the two kill addresses is marked
// dead. A dead entry stays in the buffer until it reaches the head and is popped.
// Ports:
//   clk, resetn        - clock, synchronous active-low reset
//   enq_valid/rd/data  - append one entry at the tail (caller guarantees space)
//   kill_a, kill_b     - register ids written by the pipes this cycle (0 = none)
//   pop_cnt            - number of head entries (0..2) to remove this cycle
//   head0, head1       - oldest and second-oldest entries; .valid means live
//                        after this cycle's kill
//   head0_present,
//   head1_present      - entry exists (live or dead)
//   count              - occupancy 0..DEPTH
//   pending_mask       - one bit per register targeted by a live entry
module wb_queue
    import wb_pkg::*;
#(
    parameter int DEPTH = WB_DEPTH
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     enq_valid,
    input  regid_t                   enq_rd,
    input  word_t                    enq_data,
    input  regid_t                   kill_a,
    input  regid_t                   kill_b,
    input  logic [1:0]               pop_cnt,
    output wb_req_t                  head0,
    output wb_req_t                  head1,
    output logic                     head0_present,
    output logic                     head1_present,
    output logic [$clog2(DEPTH):0]   count,
    output logic [31:0]              pending_mask
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    regid_t           rd_q   [DEPTH];
    word_t            data_q [DEPTH];
    logic [DEPTH-1:0] live_q;
    logic [DEPTH-1:0] kill_hit;
    logic [PW-1:0]    head_ptr;
    logic [PW-1:0]    head_nxt;
    logic [PW-1:0]    tail_ptr;
    logic [CW-1:0]    count_q;

    // DEPTH is a power of two, so pointer overflow wraps modulo DEPTH.
    assign head_nxt = head_ptr + PW'(1);
    assign count    = count_q;

    // A zero kill address never matches, because rd==0 is never enqueued.
    always_comb begin
        kill_hit = '0;
        for (int i = 0; i < DEPTH; i++) begin
            kill_hit[i] = ((kill_a != '0) && (rd_q[i] == kill_a)) ||
                          ((kill_b != '0) && (rd_q[i] == kill_b));
        end
    end

    // Popped slots have their live bit cleared, so stale slots never appear
    // in the mask.
    always_comb begin
        pending_mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (live_q[i]) begin
                pending_mask[rd_q[i]] = 1'b1;
            end
        end
        pending_mask[0] = 1'b0;
    end

    assign head0_present = (count_q != '0);
    assign head1_present = (count_q > CW'(1));

    always_comb begin
        head0.valid = head0_present & live_q[head_ptr] & ~kill_hit[head_ptr];
        head0.rd    = rd_q[head_ptr];
        head0.data  = data_q[head_ptr];
        head1.valid = head1_present & live_q[head_nxt] & ~kill_hit[head_nxt];
        head1.rd    = rd_q[head_nxt];
        head1.data  = data_q[head_nxt];
    end

    // The tail slot is never occupied when enq_valid is set, so the new live
    // bit overrides any kill or pop update to that slot.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            head_ptr <= '0;
            tail_ptr <= '0;
            count_q  <= '0;
            live_q   <= '0;
        end else begin
            live_q <= live_q & ~kill_hit;
            if (pop_cnt != 2'd0) begin
                live_q[head_ptr] <= 1'b0;
            end
            if (pop_cnt == 2'd2) begin
                live_q[head_nxt] <= 1'b0;
            end
            if (enq_valid) begin
                rd_q[tail_ptr]   <= enq_rd;
                data_q[tail_ptr] <= enq_data;
                live_q[tail_ptr] <= 1'b1;
                tail_ptr         <= tail_ptr + PW'(1);
            end
            head_ptr <= head_ptr + PW'(pop_cnt);
            count_q  <= count_q + CW'(enq_valid) - CW'(pop_cnt);
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// wb_arbiter: merges the two in-order pipe results and queued long-latency
// results onto the two register-file write ports through one output register
// stage.
// Ports:
//   clk, resetn              - clock, synchronous active-low reset
//   p1_valid/p1_rd/p1_data   - pipe-1 (older) result, owns write port 1
//   p2_valid/p2_rd/p2_data   - pipe-2 (younger) result, owns write port 2
//   ll_valid/ll_rd/ll_data   - long-latency result offer; ll_ready accepts it
//   we1/wa1/wd1, we2/wa2/wd2 - registered write ports (port 2 wins on equal
//                              address in the register file)
//   pending_mask             - registers with a live queued result
module wb_arbiter
    import wb_pkg::*;
#(
    parameter int DEPTH = WB_DEPTH
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        p1_valid,
    input  regid_t      p1_rd,
    input  word_t       p1_data,
    input  logic        p2_valid,
    input  regid_t      p2_rd,
    input  word_t       p2_data,
    input  logic        ll_valid,
    output logic        ll_ready,
    input  regid_t      ll_rd,
    input  word_t       ll_data,
    output logic        we1,
    output regid_t      wa1,
    output word_t       wd1,
    output logic        we2,
    output regid_t      wa2,
    output word_t       wd2,
    output logic [31:0] pending_mask
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic          p1_ok;
    logic          p2_ok;
    logic          enq;
    regid_t        kill_a;
    regid_t        kill_b;
    wb_req_t       h0;
    wb_req_t       h1;
    logic          h0_present;
    logic          h1_present;
    logic [CW-1:0] count;
    logic [1:0]    pop_cnt;
    logic          free1;
    logic          free2;
    logic          q1_use;
    logic          q1_sel;
    logic          q2_use;
    logic          q2_sel;
    regid_t        q1_rd;
    word_t         q1_data;
    regid_t        q2_rd;
    word_t         q2_data;

    // Writes to r0 are meaningless, so rd==0 counts as no write.
    assign p1_ok  = p1_valid & (p1_rd != '0);
    assign p2_ok  = p2_valid & (p2_rd != '0);
    assign kill_a = p1_ok ? p1_rd : '0;
    assign kill_b = p2_ok ? p2_rd : '0;

    // Readiness depends only on the registered occupancy, so a full queue
    // stays closed even in a cycle that pops.
    assign ll_ready = (count < CW'(DEPTH)) & resetn;
    assign enq      = ll_valid & ll_ready & (ll_rd != '0);

    wb_queue #(.DEPTH(DEPTH)) u_queue (
        .clk           (clk),
        .resetn        (resetn),
        .enq_valid     (enq),
        .enq_rd        (ll_rd),
        .enq_data      (ll_data),
        .kill_a        (kill_a),
        .kill_b        (kill_b),
        .pop_cnt       (pop_cnt),
        .head0         (h0),
        .head1         (h1),
        .head0_present (h0_present),
        .head1_present (h1_present),
        .count         (count),
        .pending_mask  (pending_mask)
    );

    // Walk the two oldest entries in order. A dead entry pops for free. A
    // live entry takes the lowest free port. A live entry with no port
    // blocks everything behind it.
    always_comb begin
        free1   = ~p1_ok;
        free2   = ~p2_ok;
        pop_cnt = 2'd0;
        q1_use  = 1'b0;
        q1_sel  = 1'b0;
        q2_use  = 1'b0;
        q2_sel  = 1'b0;
        if (h0_present) begin
            if (!h0.valid) begin
                pop_cnt = 2'd1;
            end else if (free1) begin
                q1_use  = 1'b1;
                free1   = 1'b0;
                pop_cnt = 2'd1;
            end else if (free2) begin
                q2_use  = 1'b1;
                free2   = 1'b0;
                pop_cnt = 2'd1;
            end
        end
        if ((pop_cnt == 2'd1) && h1_present) begin
            if (!h1.valid) begin
                pop_cnt = 2'd2;
            end else if (free1) begin
                q1_use  = 1'b1;
                q1_sel  = 1'b1;
                pop_cnt = 2'd2;
            end else if (free2) begin
                q2_use  = 1'b1;
                q2_sel  = 1'b1;
                pop_cnt = 2'd2;
            end
        end
    end

    assign q1_rd   = q1_sel ? h1.rd   : h0.rd;
    assign q1_data = q1_sel ? h1.data : h0.data;
    assign q2_rd   = q2_sel ? h1.rd   : h0.rd;
    assign q2_data = q2_sel ? h1.data : h0.data;

    // Address and data are forced to zero whenever the port is idle.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            we1 <= 1'b0;
            wa1 <= '0;
            wd1 <= '0;
            we2 <= 1'b0;
            wa2 <= '0;
            wd2 <= '0;
        end else begin
            we1 <= p1_ok | q1_use;
            wa1 <= p1_ok ? p1_rd   : (q1_use ? q1_rd   : '0);
            wd1 <= p1_ok ? p1_data : (q1_use ? q1_data : '0);
            we2 <= p2_ok | q2_use;
            wa2 <= p2_ok ? p2_rd   : (q2_use ? q2_rd   : '0);
            wd2 <= p2_ok ? p2_data : (q2_use ? q2_data : '0);
        end
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: directed self-checking bench for wb_arbiter (DEPTH = 4).
// Inputs are driven 1 ns after the rising edge. After tick() returns, outputs
// show the registered result of the inputs applied during the cycle that just
// ended.
module tb_wb_arbiter;
    import wb_pkg::*;

    logic        clk = 1'b0;
    logic        resetn;
    logic        p1_valid, p2_valid, ll_valid;
    regid_t      p1_rd, p2_rd, ll_rd;
    word_t       p1_data, p2_data, ll_data;
    logic        ll_ready;
    logic        we1, we2;
    regid_t      wa1, wa2;
    word_t       wd1, wd2;
    logic [31:0] pending_mask;

    int total = 0;
    int bad   = 0;

    wb_arbiter #(.DEPTH(4)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .p1_valid     (p1_valid),
        .p1_rd        (p1_rd),
        .p1_data      (p1_data),
        .p2_valid     (p2_valid),
        .p2_rd        (p2_rd),
        .p2_data      (p2_data),
        .ll_valid     (ll_valid),
        .ll_ready     (ll_ready),
        .ll_rd        (ll_rd),
        .ll_data      (ll_data),
        .we1          (we1),
        .wa1          (wa1),
        .wd1          (wd1),
        .we2          (we2),
        .wa2          (wa2),
        .wd2          (wd2),
        .pending_mask (pending_mask)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%h expected 0x%h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic v1, input int r1, input int d1,
                                 input logic v2, input int r2, input int d2,
                                 input logic vl, input int rl, input int dl);
        p1_valid = v1; p1_rd = 5'(r1); p1_data = 32'(d1);
        p2_valid = v2; p2_rd = 5'(r2); p2_data = 32'(d2);
        ll_valid = vl; ll_rd = 5'(rl); ll_data = 32'(dl);
    endtask

    task automatic idle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkPorts(input string tag, input logic e1, input int a1, input int d1,
                              input logic e2, input int a2, input int d2);
        checkOutput({tag, ".we1"}, 32'(we1), 32'(e1));
        checkOutput({tag, ".wa1"}, 32'(wa1), 32'(a1));
        checkOutput({tag, ".wd1"}, wd1, 32'(d1));
        checkOutput({tag, ".we2"}, 32'(we2), 32'(e2));
        checkOutput({tag, ".wa2"}, 32'(wa2), 32'(a2));
        checkOutput({tag, ".wd2"}, wd2, 32'(d2));
    endtask

    initial begin
        resetn = 1'b0;
        idle();

        // Reset holds the ports quiet even with a valid pipe result.
        applyStimulus(1, 3, 'h44, 0, 0, 0, 0, 0, 0);
        tick();
        tick();
        checkPorts("reset", 0, 0, 0, 0, 0, 0);
        checkOutput("reset.ll_ready", 32'(ll_ready), 0);
        checkOutput("reset.pending", pending_mask, 0);
        resetn = 1'b1;
        idle();
        #1;
        checkOutput("release.ll_ready", 32'(ll_ready), 1);
        checkOutput("release.pending", pending_mask, 0);
        tick();

        // Both pipes writing r3: both ports issue.
        applyStimulus(1, 3, 'h11, 1, 3, 'h22, 0, 0, 0);
        tick();
        checkPorts("pass", 1, 3, 'h11, 1, 3, 'h22);
        idle();
        tick();
        checkPorts("pass_idle", 0, 0, 0, 0, 0, 0);

        // Drain into idle ports: r5 appears two cycles after acceptance.
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 5, 'hA);
        checkOutput("drain.ready0", 32'(ll_ready), 1);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 6, 'hB);
        checkOutput("drain.pend5", pending_mask, 32'h0000_0020);
        checkPorts("drain.t1", 0, 0, 0, 0, 0, 0);
        tick();
        checkPorts("drain.r5", 1, 5, 'hA, 0, 0, 0);
        checkOutput("drain.pend6", pending_mask, 32'h0000_0040);
        applyStimulus(1, 1, 'h100, 0, 0, 0, 0, 0, 0);
        tick();
        checkPorts("drain.r6p2", 1, 1, 'h100, 1, 6, 'hB);
        checkOutput("drain.pend0", pending_mask, 0);
        idle();
        tick();

        // Kill: a younger p2 write to r7 cancels the queued r7.
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 7, 'h5);
        tick();
        applyStimulus(0, 0, 0, 1, 7, 'h9, 0, 0, 0);
        checkOutput("kill.pend7", pending_mask, 32'h0000_0080);
        tick();
        checkPorts("kill.p2", 0, 0, 0, 1, 7, 'h9);
        checkOutput("kill.pend_clr", pending_mask, 0);
        idle();
        tick();
        checkPorts("kill.dead", 0, 0, 0, 0, 0, 0);

        // Fill the queue while both pipes are busy.
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1, 1, 'h1000 + i, 1, 2, 'h2000 + i, 1, 10 + i, 'h200 + i);
            checkOutput($sformatf("fill.ready%0d", i), 32'(ll_ready), 1);
            tick();
            checkPorts($sformatf("fill.pipes%0d", i), 1, 1, 'h1000 + i, 1, 2, 'h2000 + i);
        end
        checkOutput("full.pend", pending_mask, 32'h0000_3C00);
        applyStimulus(1, 1, 'h1100, 1, 2, 'h2100, 1, 14, 'hDEAD);
        checkOutput("full.ready", 32'(ll_ready), 0);
        tick();
        // Pipes free; a full queue stays closed in the cycle it pops.
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 14, 'hDEAD);
        checkOutput("full.held", 32'(ll_ready), 0);
        checkOutput("full.pend_held", pending_mask, 32'h0000_3C00);
        tick();
        checkPorts("full.d1", 1, 10, 'h200, 1, 11, 'h201);
        checkOutput("full.reopen", 32'(ll_ready), 1);
        tick();
        checkPorts("full.d2", 1, 12, 'h202, 1, 13, 'h203);
        idle();
        tick();
        checkPorts("full.d3", 1, 14, 'hDEAD, 0, 0, 0);
        tick();
        checkPorts("full.empty", 0, 0, 0, 0, 0, 0);
        checkOutput("full.pend0", pending_mask, 0);

        // Twelve back-to-back transfers wrap the pointers three times.
        for (int i = 0; i <= 12; i++) begin
            if (i < 12) begin
                applyStimulus(0, 0, 0, 0, 0, 0, 1, 16 + (i % 8), 'h300 + i);
                checkOutput($sformatf("wrap.ready%0d", i), 32'(ll_ready), 1);
            end else begin
                idle();
            end
            tick();
            if (i >= 1) begin
                checkPorts($sformatf("wrap%0d", i - 1), 1, 16 + ((i - 1) % 8), 'h300 + i - 1,
                           0, 0, 0);
            end
        end
        idle();
        tick();
        checkPorts("wrap.done", 0, 0, 0, 0, 0, 0);

        // rd==0: the ll is accepted and dropped, and the pipe write is ignored.
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 0, 'h77);
        checkOutput("r0.ready", 32'(ll_ready), 1);
        tick();
        applyStimulus(1, 0, 'h55, 0, 0, 0, 0, 0, 0);
        checkOutput("r0.pend", pending_mask, 0);
        tick();
        checkPorts("r0.ports", 0, 0, 0, 0, 0, 0);
        idle();
        tick();
        checkPorts("r0.after", 0, 0, 0, 0, 0, 0);

        // Reset mid-operation discards a queued result.
        applyStimulus(1, 1, 'h1, 1, 2, 'h2, 1, 9, 'h99);
        tick();
        checkOutput("midrst.pend9", pending_mask, 32'h0000_0200);
        resetn = 1'b0;
        idle();
        tick();
        checkOutput("midrst.pend0", pending_mask, 0);
        checkPorts("midrst.ports", 0, 0, 0, 0, 0, 0);
        resetn = 1'b1;
        tick();
        tick();
        checkPorts("midrst.nodrain", 0, 0, 0, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
